// File: rtl/mem_wb_stage_hs.sv
// Memory/write-back stage: issues one request per memory op over a req/ack port,
// stalls upstream while it is outstanding, and registers the write-back result.
`timescale 1ns/1ps
module mem_wb_stage_hs #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int REG_W     = 3,
  parameter int TIMEOUT   = 64,
  parameter int ALIGN_CHK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall_in,
  input  logic              halt,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic              reg_wrt,
  input  logic [2:0]        wb_src,
  input  logic [REG_W-1:0]  write_reg,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] set_val,
  input  logic [DATA_W-1:0] reg1_data,
  input  logic [DATA_W-1:0] reg2_data,
  input  logic [DATA_W-1:0] next_pc,
  input  logic [DATA_W-1:0] instr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              mem_err,
  output logic              busy,
  output logic [DATA_W-1:0] fwd_data,
  output logic              out_valid,
  output logic              reg_wrt_out,
  output logic [REG_W-1:0]  write_reg_out,
  output logic [2:0]        wb_src_out,
  output logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              err,
  output logic              mem_dump,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_req_q;
  logic [2:0]          h_src_q;
  logic [REG_W-1:0]    h_reg_q;
  logic                h_wrt_q;
  logic                h_we_q;
  logic [ADDR_W-1:0]   h_addr_q;
  logic [DATA_W-1:0]   h_wdata_q;
  logic [DATA_W-1:0]   h_val_q;
  logic [DATA_W-1:0]   h_rd_q;
  logic                h_err_q;
  logic                out_valid_q;
  logic                reg_wrt_out_q;
  logic [REG_W-1:0]    write_reg_out_q;
  logic [2:0]          wb_src_out_q;
  logic [DATA_W-1:0]   mem_out_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                err_q;
  logic                mem_dump_q;

  logic                accept, acc_alu, acc_mem;
  logic                misalign, in_err;
  logic                in_wait, tmo, done;
  logic [DATA_W-1:0]   ld_rd;
  logic                ld_err;
  logic                err_set, err_d, dump_d;
  logic                ld_en, ld_wrt, ld_ierr;
  logic [REG_W-1:0]    ld_reg;
  logic [2:0]          ld_src;
  logic [DATA_W-1:0]   ld_mem, ld_wb;
  logic                unused_instr_hi;

  assign unused_instr_hi = ^instr[DATA_W-1:8];

  function automatic logic [DATA_W-1:0] src_mux(
    input logic [2:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] npc,
    input logic [DATA_W-1:0] setv,
    input logic [DATA_W-1:0] ins,
    input logic [DATA_W-1:0] r1
  );
    logic [DATA_W-1:0] v;
    v = '0;
    case (sel)
      3'd1: v = alu;
      3'd2: v = npc;
      3'd3: v = setv;
      3'd4: v = {{(DATA_W-8){ins[7]}}, ins[7:0]};
      3'd5: v = {r1[DATA_W-9:0], ins[7:0]};
      3'd6: for (int i = 0; i < DATA_W; i++) v[i] = r1[DATA_W-1-i];
      default: v = '0;
    endcase
    return v;
  endfunction

  // Memory handshake: mem_req is held high from the cycle after accept until the
  // cycle in which mem_ack is seen; mem_we/mem_addr/mem_wdata stay constant for
  // that whole window. mem_rdata and mem_err are only sampled with mem_ack in WAIT.
  assign fwd_data = src_mux(wb_src, alu_out, next_pc, set_val, instr, reg1_data);
  assign busy     = (state_q != S_IDLE) | stall_in;
  assign accept   = (state_q == S_IDLE) & in_valid & ~stall_in;
  assign acc_alu  = accept & ~mem_en;
  assign acc_mem  = accept & mem_en;
  assign misalign = (ALIGN_CHK != 0) & mem_en & alu_out[0];
  assign in_err   = (wb_src == 3'd7) | misalign;

  assign in_wait = (state_q == S_WAIT);
  assign tmo     = in_wait & ~mem_ack & (cnt_q == CNT_W'(TIMEOUT - 1));
  assign done    = in_wait & (mem_ack | tmo);
  // A timed-out access completes like an ack with zero read data.
  assign ld_rd   = (mem_ack & ~h_we_q) ? mem_rdata : '0;
  assign ld_err  = h_err_q | tmo | (mem_ack & mem_err);

  assign err_set = (accept & in_err) | (in_wait & mem_ack & mem_err) | tmo;
  assign err_d   = err_q | err_set;
  assign dump_d  = (err_set & ~err_q) | (accept & halt);

  always_comb begin
    ld_en   = 1'b0;
    ld_wrt  = h_wrt_q;
    ld_ierr = h_err_q;
    ld_reg  = h_reg_q;
    ld_src  = h_src_q;
    ld_mem  = h_rd_q;
    ld_wb   = (h_src_q == 3'd0) ? h_rd_q : h_val_q;
    if (acc_alu) begin
      ld_en   = 1'b1;
      ld_wrt  = reg_wrt;
      ld_ierr = in_err;
      ld_reg  = write_reg;
      ld_src  = wb_src;
      ld_mem  = '0;
      ld_wb   = fwd_data;
    end else if (done & ~stall_in) begin
      ld_en   = 1'b1;
      ld_ierr = ld_err;
      ld_mem  = ld_rd;
      ld_wb   = (h_src_q == 3'd0) ? ld_rd : h_val_q;
    end else if ((state_q == S_HOLD) & ~stall_in) begin
      ld_en   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      mem_req_q       <= 1'b0;
      h_src_q         <= '0;
      h_reg_q         <= '0;
      h_wrt_q         <= 1'b0;
      h_we_q          <= 1'b0;
      h_addr_q        <= '0;
      h_wdata_q       <= '0;
      h_val_q         <= '0;
      h_rd_q          <= '0;
      h_err_q         <= 1'b0;
      out_valid_q     <= 1'b0;
      reg_wrt_out_q   <= 1'b0;
      write_reg_out_q <= '0;
      wb_src_out_q    <= '0;
      mem_out_q       <= '0;
      wb_data_q       <= '0;
      err_q           <= 1'b0;
      mem_dump_q      <= 1'b0;
    end else begin
      err_q      <= err_d;
      mem_dump_q <= dump_d;

      case (state_q)
        S_IDLE: begin
          if (acc_mem) begin
            h_src_q   <= wb_src;
            h_reg_q   <= write_reg;
            h_wrt_q   <= reg_wrt;
            h_we_q    <= mem_wr;
            h_addr_q  <= alu_out[ADDR_W-1:0];
            h_wdata_q <= reg2_data;
            h_val_q   <= fwd_data;
            h_err_q   <= in_err;
            h_rd_q    <= '0;
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done) begin
            mem_req_q <= 1'b0;
            h_rd_q    <= ld_rd;
            h_err_q   <= ld_err;
            state_q   <= stall_in ? S_HOLD : S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (!stall_in) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Output register: load, hold under stall, or drop to a bubble.
      if (ld_en) begin
        out_valid_q     <= 1'b1;
        reg_wrt_out_q   <= ld_wrt & ~ld_ierr;
        write_reg_out_q <= ld_reg;
        wb_src_out_q    <= ld_src;
        mem_out_q       <= ld_mem;
        wb_data_q       <= ld_wb;
      end else if (!stall_in) begin
        out_valid_q   <= 1'b0;
        reg_wrt_out_q <= 1'b0;
      end
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_req_q & h_we_q;
  assign mem_addr      = h_addr_q;
  assign mem_wdata     = h_wdata_q;
  assign out_valid     = out_valid_q;
  assign reg_wrt_out   = reg_wrt_out_q;
  assign write_reg_out = write_reg_out_q;
  assign wb_src_out    = wb_src_out_q;
  assign mem_out       = mem_out_q;
  assign wb_data       = wb_data_q;
  assign err           = err_q;
  assign mem_dump      = mem_dump_q;
  assign state_dbg     = state_q;

endmodule
